// File: rtl/chess_board_store_pkg.sv
// Shared definitions for the chess board store: figure codes, FSM states and
// the start-position lookup used by the board ROM.
package chess_board_store_pkg;

    typedef logic [3:0] fig_code_t;

    localparam fig_code_t FIG_EMPTY    = 4'd0;
    localparam fig_code_t FIG_W_PAWN   = 4'd1;
    localparam fig_code_t FIG_W_BISHOP = 4'd2;
    localparam fig_code_t FIG_W_KNIGHT = 4'd3;
    localparam fig_code_t FIG_W_ROOK   = 4'd4;
    localparam fig_code_t FIG_W_QUEEN  = 4'd5;
    localparam fig_code_t FIG_W_KING   = 4'd6;
    localparam fig_code_t FIG_B_PAWN   = 4'd7;
    localparam fig_code_t FIG_B_BISHOP = 4'd8;
    localparam fig_code_t FIG_B_KNIGHT = 4'd9;
    localparam fig_code_t FIG_B_ROOK   = 4'd10;
    localparam fig_code_t FIG_B_QUEEN  = 4'd11;
    localparam fig_code_t FIG_B_KING   = 4'd12;

    // Each black piece code sits a fixed distance above its white counterpart.
    localparam fig_code_t BLACK_OFFSET = FIG_B_PAWN - FIG_W_PAWN;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_CHECK,
        ST_COMMIT,
        ST_DONE
    } board_state_t;

    function automatic fig_code_t white_back_rank(input int col);
        fig_code_t code;
        case (col)
            0, 7:    code = FIG_W_ROOK;
            1, 6:    code = FIG_W_KNIGHT;
            2, 5:    code = FIG_W_BISHOP;
            3:       code = FIG_W_QUEEN;
            4:       code = FIG_W_KING;
            default: code = FIG_EMPTY;
        endcase
        return code;
    endfunction

    function automatic fig_code_t start_code(input int row, input int col, input int board_h);
        fig_code_t code;
        code = FIG_EMPTY;
        if (row == 0) begin
            code = white_back_rank(col);
            if (code != FIG_EMPTY) code = code + BLACK_OFFSET;
        end else if (row == 1) begin
            code = FIG_B_PAWN;
        end else if (row == board_h - 2) begin
            code = FIG_W_PAWN;
        end else if (row == board_h - 1) begin
            code = white_back_rank(col);
        end
        return code;
    endfunction

endpackage

// File: rtl/chess_board_store_if.sv
// Read port and move handshake between game logic / renderer (master) and the
// board store (slave).
interface chess_board_store_if #(
    parameter int COORD_W = 4,
    parameter int CODE_W  = 6
) ();

    logic [2*COORD_W-1:0] figure_xy;
    logic [CODE_W-1:0]    figure_code;
    logic                 init_req;
    logic                 move_valid;
    logic                 move_ready;
    logic [2*COORD_W-1:0] move_from;
    logic [2*COORD_W-1:0] move_to;
    logic                 move_done;
    logic                 move_err;
    logic [CODE_W-1:0]    captured_code;
    logic                 busy;

    modport master (
        output figure_xy, init_req, move_valid, move_from, move_to,
        input  figure_code, move_ready, move_done, move_err, captured_code, busy
    );

    modport slave (
        input  figure_xy, init_req, move_valid, move_from, move_to,
        output figure_code, move_ready, move_done, move_err, captured_code, busy
    );

endinterface

// File: rtl/chess_board_store_rom.sv
// Combinational start-position row: row index in, packed codes for all columns
// out (column 0 in the least significant code slot).
module board_start_rom
    import chess_board_store_pkg::*;
#(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8,
    parameter int COORD_W = 4,
    parameter int CODE_W  = 6
) (
    input  logic [COORD_W-1:0]        row_i,
    output logic [BOARD_W*CODE_W-1:0] codes_o
);

    always_comb begin
        codes_o = '0;
        for (int c = 0; c < BOARD_W; c++) begin
            codes_o[c*CODE_W +: CODE_W] = CODE_W'(start_code(32'(row_i), c, BOARD_H));
        end
    end

endmodule

// File: rtl/chess_board_store.sv
// Board occupancy register file with a 1-cycle read port for the renderer and
// a handshaked move engine that reports captures and rejects malformed moves.
module chess_board_store
    import chess_board_store_pkg::*;
#(
    parameter int BOARD_W = 8,
    parameter int BOARD_H = 8,
    parameter int COORD_W = 4,
    parameter int CODE_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    chess_board_store_if.slave  bus
);

    localparam logic [COORD_W:0]   ROW_LIM  = (COORD_W+1)'(BOARD_H);
    localparam logic [COORD_W:0]   COL_LIM  = (COORD_W+1)'(BOARD_W);
    localparam logic [COORD_W-1:0] LAST_ROW = COORD_W'(BOARD_H - 1);

    typedef logic [2*COORD_W-1:0] sq_t;
    typedef logic [CODE_W-1:0]    code_t;

    code_t                      board_q [BOARD_H][BOARD_W];
    logic [BOARD_W*CODE_W-1:0]  rom_rows [BOARD_H];

    board_state_t               state_q;
    logic [COORD_W-1:0]         init_cnt_q;
    sq_t                        from_q;
    sq_t                        to_q;
    code_t                      src_q;
    code_t                      cap_q;
    code_t                      figure_code_q;
    code_t                      captured_q;
    logic                       move_done_q;
    logic                       move_err_q;

    // One constant ROM row per board row lets reset load everything at once
    // while INIT picks a single row by counter.
    for (genvar gr = 0; gr < BOARD_H; gr++) begin : g_rom
        board_start_rom #(
            .BOARD_W (BOARD_W),
            .BOARD_H (BOARD_H),
            .COORD_W (COORD_W),
            .CODE_W  (CODE_W)
        ) u_rom (
            .row_i   (COORD_W'(gr)),
            .codes_o (rom_rows[gr])
        );
    end

    function automatic logic in_range(input sq_t xy);
        return ({1'b0, xy[2*COORD_W-1:COORD_W]} < ROW_LIM) &&
               ({1'b0, xy[COORD_W-1:0]} < COL_LIM);
    endfunction

    // Out-of-range squares match no cell and therefore read as empty.
    function automatic code_t read_sq(input sq_t xy);
        code_t code;
        code = '0;
        for (int r = 0; r < BOARD_H; r++) begin
            for (int c = 0; c < BOARD_W; c++) begin
                if (xy[2*COORD_W-1:COORD_W] == COORD_W'(r) && xy[COORD_W-1:0] == COORD_W'(c))
                    code = board_q[r][c];
            end
        end
        return code;
    endfunction

    // NOTE: non-blocking assignments everywhere below, so the read port and the
    // CHECK stage see pre-edge board contents even when a write lands on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            init_cnt_q    <= '0;
            from_q        <= '0;
            to_q          <= '0;
            src_q         <= '0;
            cap_q         <= '0;
            figure_code_q <= '0;
            captured_q    <= '0;
            move_done_q   <= 1'b0;
            move_err_q    <= 1'b0;
            // NOTE: the board is flops, not RAM, so reset loads the full start layout.
            for (int r = 0; r < BOARD_H; r++) begin
                for (int c = 0; c < BOARD_W; c++) begin
                    board_q[r][c] <= rom_rows[r][c*CODE_W +: CODE_W];
                end
            end
        end else begin
            figure_code_q <= read_sq(bus.figure_xy);
            move_done_q   <= 1'b0;
            move_err_q    <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (bus.init_req) begin
                        init_cnt_q <= '0;
                        state_q    <= ST_INIT;
                    end else if (bus.move_valid) begin
                        from_q  <= bus.move_from;
                        to_q    <= bus.move_to;
                        state_q <= ST_CHECK;
                    end
                end

                ST_INIT: begin
                    for (int r = 0; r < BOARD_H; r++) begin
                        if (init_cnt_q == COORD_W'(r)) begin
                            for (int c = 0; c < BOARD_W; c++) begin
                                board_q[r][c] <= rom_rows[r][c*CODE_W +: CODE_W];
                            end
                        end
                    end
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == LAST_ROW) state_q <= ST_IDLE;
                end

                ST_CHECK: begin
                    if (!in_range(from_q) || !in_range(to_q) || from_q == to_q ||
                        read_sq(from_q) == '0) begin
                        move_err_q <= 1'b1;
                        state_q    <= ST_IDLE;
                    end else begin
                        src_q   <= read_sq(from_q);
                        cap_q   <= read_sq(to_q);
                        state_q <= ST_COMMIT;
                    end
                end

                ST_COMMIT: begin
                    for (int r = 0; r < BOARD_H; r++) begin
                        for (int c = 0; c < BOARD_W; c++) begin
                            if (to_q == {COORD_W'(r), COORD_W'(c)})
                                board_q[r][c] <= src_q;
                            else if (from_q == {COORD_W'(r), COORD_W'(c)})
                                board_q[r][c] <= '0;
                        end
                    end
                    captured_q  <= cap_q;
                    move_done_q <= 1'b1;
                    state_q     <= ST_DONE;
                end

                ST_DONE: state_q <= ST_IDLE;

                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.figure_code   = figure_code_q;
    assign bus.move_done     = move_done_q;
    assign bus.move_err      = move_err_q;
    assign bus.captured_code = captured_q;
    assign bus.busy          = (state_q != ST_IDLE);
    assign bus.move_ready    = (state_q == ST_IDLE) && !bus.init_req;

endmodule

// File: tb/tb_chess_board_store.sv
// Directed bench for chess_board_store: an 8x8 and a 10x6 instance share the
// clock and reset; sel_b routes requests and observed outputs to one of them.
module tb_chess_board_store;

    logic       clk = 1'b0;
    logic       rst;
    logic       sel_b;
    logic       init_req;
    logic       move_valid;
    logic [7:0] xy;
    logic [7:0] from_sq;
    logic [7:0] to_sq;

    always #5 clk = ~clk;

    chess_board_store_if #(.COORD_W(4), .CODE_W(6)) bus_a ();
    chess_board_store_if #(.COORD_W(4), .CODE_W(6)) bus_b ();

    assign bus_a.figure_xy  = xy;
    assign bus_a.move_from  = from_sq;
    assign bus_a.move_to    = to_sq;
    assign bus_a.init_req   = init_req & ~sel_b;
    assign bus_a.move_valid = move_valid & ~sel_b;
    assign bus_b.figure_xy  = xy;
    assign bus_b.move_from  = from_sq;
    assign bus_b.move_to    = to_sq;
    assign bus_b.init_req   = init_req & sel_b;
    assign bus_b.move_valid = move_valid & sel_b;

    chess_board_store #(.BOARD_W(8), .BOARD_H(8), .COORD_W(4), .CODE_W(6)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    chess_board_store #(.BOARD_W(10), .BOARD_H(6), .COORD_W(4), .CODE_W(6)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    logic [5:0] code, cap;
    logic       ready, done, err, busy;

    always_comb begin
        if (sel_b) begin
            code = bus_b.figure_code; cap = bus_b.captured_code; ready = bus_b.move_ready;
            done = bus_b.move_done;   err = bus_b.move_err;      busy  = bus_b.busy;
        end else begin
            code = bus_a.figure_code; cap = bus_a.captured_code; ready = bus_a.move_ready;
            done = bus_a.move_done;   err = bus_a.move_err;      busy  = bus_a.busy;
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference board for whichever instance is selected.
    int         cur_w, cur_h;
    int         back_w [8];
    int         back_b [8];
    logic [5:0] model [16][16];

    function automatic logic [5:0] exp_start(input int r, input int c);
        if (r >= cur_h || c >= cur_w) return 6'd0;
        if (r == 0)         return (c < 8) ? 6'(back_b[c]) : 6'd0;
        if (r == 1)         return 6'd7;
        if (r == cur_h - 2) return 6'd1;
        if (r == cur_h - 1) return (c < 8) ? 6'(back_w[c]) : 6'd0;
        return 6'd0;
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                model[r][c] = exp_start(r, c);
    endtask

    task automatic rd_check(input logic [7:0] a, input logic [5:0] e, input string tag);
        xy = a;
        step();
        check($sformatf("%s rd %h", tag, a), code, e);
    endtask

    task automatic sweep(input string tag);
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 11; c++)
                rd_check({4'(r), 4'(c)}, model[r][c], tag);
    endtask

    task automatic do_move(input logic [7:0] f, input logic [7:0] t, input bit exp_err,
                           input logic [5:0] exp_cap, input string nm);
        logic [5:0] cap_before;
        cap_before = cap;
        from_sq = f; to_sq = t; move_valid = 1'b1;
        #1;
        check({nm, " ready@T"}, ready, 1);
        step();
        move_valid = 1'b0;
        check({nm, " busy@T+1"}, busy, 1);
        check({nm, " done@T+1"}, done, 0);
        check({nm, " err@T+1"}, err, 0);
        step();
        if (exp_err) begin
            check({nm, " err@T+2"}, err, 1);
            check({nm, " done@T+2"}, done, 0);
            check({nm, " busy@T+2"}, busy, 0);
            check({nm, " cap held"}, cap, cap_before);
            step();
            check({nm, " err@T+3"}, err, 0);
            check({nm, " done@T+3"}, done, 0);
        end else begin
            check({nm, " err@T+2"}, err, 0);
            check({nm, " done@T+2"}, done, 0);
            step();
            check({nm, " done@T+3"}, done, 1);
            check({nm, " cap@T+3"}, cap, exp_cap);
            step();
            check({nm, " done@T+4"}, done, 0);
            check({nm, " ready@T+4"}, ready, 1);
            model[int'(t[7:4])][int'(t[3:0])] = model[int'(f[7:4])][int'(f[3:0])];
            model[int'(f[7:4])][int'(f[3:0])] = 6'd0;
        end
    endtask

    task automatic rst_in_commit(input logic [7:0] f, input logic [7:0] t, input string nm);
        from_sq = f; to_sq = t; move_valid = 1'b1;
        step();              // T+1 CHECK
        move_valid = 1'b0;
        step();              // T+2 COMMIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        check({nm, " code after rst"}, code, 0);
        check({nm, " busy after rst"}, busy, 0);
        model_reset();
        for (int i = 0; i < 4; i++) begin
            check({nm, " no done"}, done, 0);
            check({nm, " no err"}, err, 0);
            rd_check(i[0] ? t : f, model[int'((i[0] ? t : f) >> 4)][int'((i[0] ? t : f) & 8'h0f)], nm);
        end
    endtask

    typedef struct {
        logic [7:0] xy;
        logic [5:0] exp;
    } rd_vec_t;

    rd_vec_t va [10];
    rd_vec_t vb [11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int cnt;
        bit pulse;

        back_w = '{4, 3, 2, 5, 6, 2, 3, 4};
        back_b = '{10, 9, 8, 11, 12, 8, 9, 10};

        va[0] = '{8'h00, 6'd10}; va[1] = '{8'h04, 6'd12}; va[2] = '{8'h10, 6'd7};
        va[3] = '{8'h60, 6'd1};  va[4] = '{8'h73, 6'd5};  va[5] = '{8'h33, 6'd0};
        va[6] = '{8'h08, 6'd0};  va[7] = '{8'h07, 6'd10}; va[8] = '{8'h74, 6'd6};
        va[9] = '{8'h80, 6'd0};

        vb[0] = '{8'h00, 6'd10}; vb[1] = '{8'h04, 6'd12}; vb[2] = '{8'h08, 6'd0};
        vb[3] = '{8'h09, 6'd0};  vb[4] = '{8'h18, 6'd7};  vb[5] = '{8'h40, 6'd1};
        vb[6] = '{8'h49, 6'd1};  vb[7] = '{8'h50, 6'd4};  vb[8] = '{8'h54, 6'd6};
        vb[9] = '{8'h58, 6'd0};  vb[10] = '{8'h60, 6'd0};

        rst = 1'b1; sel_b = 1'b0; init_req = 1'b0; move_valid = 1'b0;
        xy = 8'h00; from_sq = 8'h00; to_sq = 8'h00;
        cur_w = 8; cur_h = 8;
        model_reset();

        step();
        check("rst figure_code", code, 0);
        check("rst move_done", done, 0);
        check("rst move_err", err, 0);
        check("rst captured", cap, 0);
        check("rst busy", busy, 0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) rd_check(va[i].xy, va[i].exp, "A start");
        sweep("A start");

        do_move(8'h64, 8'h44, 1'b0, 6'd0, "A push");
        rd_check(8'h44, 6'd1, "A push");
        rd_check(8'h64, 6'd0, "A push");

        do_move(8'h44, 8'h14, 1'b0, 6'd7, "A capture");
        rd_check(8'h14, 6'd1, "A capture");
        rd_check(8'h44, 6'd0, "A capture");

        do_move(8'h33, 8'h43, 1'b1, 6'd0, "A err empty");
        do_move(8'h00, 8'h00, 1'b1, 6'd0, "A err same");
        do_move(8'h14, 8'h80, 1'b1, 6'd0, "A err range");
        check("A cap after errs", cap, 7);
        sweep("A after errs");

        init_req = 1'b1; move_valid = 1'b1; from_sq = 8'h61; to_sq = 8'h41;
        #1;
        check("A init ready", ready, 0);
        step();
        init_req = 1'b0; move_valid = 1'b0;
        cnt = 0; pulse = 1'b0;
        while (busy && cnt < 20) begin
            cnt++;
            pulse |= (done | err);
            step();
        end
        check("A init busy cycles", cnt, 8);
        check("A init no pulse", pulse, 0);
        model_reset();
        sweep("A after init");
        do_move(8'h61, 8'h41, 1'b0, 6'd0, "A after init");
        rd_check(8'h41, 6'd1, "A after init");

        rst_in_commit(8'h01, 8'h22, "A rst commit");
        sweep("A rst commit");

        sel_b = 1'b1; cur_w = 10; cur_h = 6;
        model_reset();
        for (int i = 0; i < 11; i++) rd_check(vb[i].xy, vb[i].exp, "B start");
        do_move(8'h18, 8'h38, 1'b0, 6'd0, "B push");
        rd_check(8'h38, 6'd7, "B push");
        rst_in_commit(8'h41, 8'h31, "B rst commit");
        sweep("B rst commit");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
